// File: rtl/sysid_check_pkg.sv
// -----------------------------------------------------------------------------
// sysid_check_pkg
// Shared definitions for the system-ID check controller: FSM state encoding,
// Avalon-MM word addresses and the retry counter width.
// Optional macro SYSID_CHECK_TIMEOUT_EN adds the S_TMO state.
// -----------------------------------------------------------------------------
package sysid_check_pkg;

    localparam int   RETRY_W = 4;
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_ID,
        S_WT_ID,
        S_RD_TS,
        S_WT_TS,
        S_CMP,
        S_PASS,
        S_FAIL
`ifdef SYSID_CHECK_TIMEOUT_EN
        , S_TMO
`endif
    } state_e;

endpackage

// File: rtl/sysid_wait_timer.sv
// -----------------------------------------------------------------------------
// sysid_wait_timer
// 16-bit wait counter used to bound slave stalls. Counts while count_i is high,
// restarts from zero when clear_i is high, and raises expire_o combinationally
// during the LIMIT-th counted cycle.
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset
//   clear_i   restart the count (state change)
//   count_i   count this cycle (controller is in a wait state)
//   expire_o  limit reached in the current cycle
// Only instantiated when SYSID_CHECK_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module sysid_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_i,
    output logic expire_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // cnt_q holds the number of completed cycles, so the LIMIT-th cycle sees LIMIT-1.
    assign expire_o = count_i && (cnt_q == 16'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !count_i) begin
            cnt_d = '0;
        end else if (!expire_o) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// sysid_check_ctrl
// Reads the system-ID word (and optionally the timestamp word) over Avalon-MM,
// compares them with the expected values, retries up to MAX_RETRY times and
// reports pass/fail. A check runs automatically after reset and again on each
// start pulse while not busy.
// Ports:
//   clock, reset_n          clock; asynchronous active-low reset
//   start                   one-cycle request for a new check (ignored when busy)
//   avm_address/avm_read    read master outputs (0 = ID word, 1 = timestamp)
//   avm_waitrequest         slave stall
//   avm_readdata/valid      read data and qualifier
//   busy/done/pass/fail     registered status flags
//   id_value/ts_value       last captured words
//   retry_cnt               retries used in the current/last check
// Optional macro SYSID_CHECK_TIMEOUT_EN: bounds every RD_*/WT_* wait by
// TIMEOUT_CYCLES and reports a timeout as fail through the S_TMO state.
// -----------------------------------------------------------------------------
module sysid_check_ctrl
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    output logic               avm_address,
    output logic               avm_read,
    input  logic               avm_waitrequest,
    input  logic [31:0]        avm_readdata,
    input  logic               avm_readdatavalid,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic [31:0]        id_value,
    output logic [31:0]        ts_value,
    output logic [RETRY_W-1:0] retry_cnt
);

    if (MAX_RETRY > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
        $error("sysid_check_ctrl: MAX_RETRY or TIMEOUT_CYCLES out of range");
    end

    localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);

    state_e               state_q, state_d;
    logic                 read_q, read_d;
    logic                 addr_q, addr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic [31:0]          id_q, id_d;
    logic [31:0]          ts_q, ts_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 match;

    assign match = (id_q == EXPECTED_ID) && (!CHECK_TS || (ts_q == EXPECTED_TS));

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic tmr_count;
    logic tmr_clear;
    logic tmr_expire;

    assign tmr_count = (state_q == S_RD_ID) || (state_q == S_WT_ID) ||
                       (state_q == S_RD_TS) || (state_q == S_WT_TS);
    assign tmr_clear = (state_d != state_q);

    sysid_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i    (clock),
        .rst_ni   (reset_n),
        .clear_i  (tmr_clear),
        .count_i  (tmr_count),
        .expire_o (tmr_expire)
    );
`endif

    // Next-state logic. Launching from IDLE/PASS/FAIL clears the retry count;
    // captured words are kept until overwritten by a new read.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ts_d    = ts_q;
        retry_d = retry_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_RD_ID;
                retry_d = '0;
            end
            S_RD_ID: begin
                if (!avm_waitrequest) state_d = S_WT_ID;
            end
            S_WT_ID: begin
                if (avm_readdatavalid) begin
                    id_d    = avm_readdata;
                    state_d = CHECK_TS ? S_RD_TS : S_CMP;
                end
            end
            S_RD_TS: begin
                if (!avm_waitrequest) state_d = S_WT_TS;
            end
            S_WT_TS: begin
                if (avm_readdatavalid) begin
                    ts_d    = avm_readdata;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (match) begin
                    state_d = S_PASS;
                end else if (retry_q < MAX_RETRY_C) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = S_RD_ID;
                end else begin
                    state_d = S_FAIL;
                end
            end
`ifdef SYSID_CHECK_TIMEOUT_EN
            S_PASS, S_FAIL, S_TMO: begin
`else
            S_PASS, S_FAIL: begin
`endif
                if (start) begin
                    state_d = S_RD_ID;
                    retry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef SYSID_CHECK_TIMEOUT_EN
        // A handshake completing in the expiring cycle still wins over the timeout.
        if (tmr_expire && (state_d == state_q)) state_d = S_TMO;
`endif
    end

    // Status and bus outputs are decoded from the next state so they change on
    // the edge that enters the state.
    always_comb begin
        read_d = (state_d == S_RD_ID) || (state_d == S_RD_TS);
        addr_d = ((state_d == S_RD_TS) || (state_d == S_WT_TS)) ? ADDR_TS : ADDR_ID;
        pass_d = (state_d == S_PASS);
`ifdef SYSID_CHECK_TIMEOUT_EN
        fail_d = (state_d == S_FAIL) || (state_d == S_TMO);
`else
        fail_d = (state_d == S_FAIL);
`endif
        done_d = pass_d || fail_d;
        busy_d = (state_d != S_IDLE) && !done_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            read_q  <= 1'b0;
            addr_q  <= ADDR_ID;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            id_q    <= '0;
            ts_q    <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            retry_q <= retry_d;
        end
    end

    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;
    assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sysid_check_ctrl
// Randomized bench for sysid_check_ctrl: an Avalon-MM slave model with random
// stalls/latency serves scripted ID/timestamp words; a reference model derives
// the expected outcome from the list of words offered per attempt.
// Define SYSID_CHECK_TIMEOUT_EN for both RTL and bench to add the timeout test.
// -----------------------------------------------------------------------------
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID = 32'h574B_4E53;
    localparam logic [31:0] EXP_TS = 32'h1234_5678;
    localparam int          MAXR   = 3;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy, done, pass, fail;
    logic [31:0] id_value, ts_value;
    logic [3:0]  retry_cnt;

    sysid_check_ctrl #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .CHECK_TS       (1'b1),
        .MAX_RETRY      (MAXR),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .fail              (fail),
        .id_value          (id_value),
        .ts_value          (ts_value),
        .retry_cnt         (retry_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Slave configuration (-1 = random 0..3) and scripted read data.
    logic [31:0] id_words [512];
    logic [31:0] ts_words [512];
    int stall_id_cfg = 0, stall_ts_cfg = 0, dly_id_cfg = 0, dly_ts_cfg = 0;
    int flush_req = 0;
    // Written only by the slave process.
    int rd_id_cnt = 0, rd_ts_cnt = 0, stab_err = 0;

    // Per-attempt words offered to the DUT and last known captured words.
    logic [31:0] att_id [4];
    logic [31:0] att_ts [4];
    logic [31:0] last_id = '0, last_ts = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int cfg);
        return (cfg < 0) ? int'($urandom_range(3, 0)) : cfg;
    endfunction

    // Avalon-MM slave model, evaluated on the falling edge.
    bit          s_pend, s_in_req, s_prev_rd, s_prev_addr;
    int          s_pend_cnt, s_stall_left, s_flush_seen;
    logic [31:0] s_pend_data;
    initial begin : slave
        s_pend = 0; s_in_req = 0; s_prev_rd = 0; s_prev_addr = 0;
        s_pend_cnt = 0; s_stall_left = 0; s_flush_seen = 0; s_pend_data = '0;
        avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0; avm_readdata = '0;
        forever begin
            @(negedge clock);
            // A stalled read must keep read and address unchanged.
            if (reset_n && s_prev_rd && avm_waitrequest &&
                (!avm_read || (avm_address != s_prev_addr))) stab_err++;
            s_prev_rd   = avm_read;
            s_prev_addr = avm_address;
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b1;
            if (s_flush_seen != flush_req) begin
                s_pend = 0; s_in_req = 0; s_flush_seen = flush_req;
            end
            if (s_pend) begin
                if (s_pend_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = s_pend_data;
                    s_pend            = 0;
                end else begin
                    s_pend_cnt--;
                end
            end else if (avm_read) begin
                if (!s_in_req) begin
                    s_in_req     = 1;
                    s_stall_left = pick(avm_address ? stall_ts_cfg : stall_id_cfg);
                end
                if (s_stall_left > 0) begin
                    s_stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    s_in_req = 0;
                    s_pend   = 1;
                    if (avm_address) begin
                        s_pend_cnt  = pick(dly_ts_cfg);
                        s_pend_data = ts_words[rd_ts_cnt % 512];
                        rd_ts_cnt++;
                    end else begin
                        s_pend_cnt  = pick(dly_id_cfg);
                        s_pend_data = id_words[rd_id_cnt % 512];
                        rd_id_cnt++;
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic load_words(input int id0, input int ts0);
        for (int a = 0; a <= MAXR; a++) begin
            id_words[(id0 + a) % 512] = att_id[a];
            ts_words[(ts0 + a) % 512] = att_ts[a];
        end
    endtask

    // Launch a check with the current att_* words and compare against the model:
    // the first attempt whose ID and timestamp both match wins, otherwise the
    // check fails after MAXR+1 attempts holding the last attempt's words.
    task automatic run_check(input string tag);
        bit exp_pass;
        int used, id0, ts0;
        exp_pass = 0;
        used     = MAXR;
        for (int a = 0; a <= MAXR; a++) begin
            if (!exp_pass && att_id[a] == EXP_ID && att_ts[a] == EXP_TS) begin
                exp_pass = 1;
                used     = a;
            end
        end
        id0 = rd_id_cnt;
        ts0 = rd_ts_cnt;
        load_words(id0, ts0);
        pulse_start();
        check({tag, "_launch_busy"}, busy, 1);
        check({tag, "_launch_done"}, done, 0);
        check({tag, "_launch_retry"}, retry_cnt, 0);
        check({tag, "_launch_idkeep"}, id_value, last_id);
        wait_done(tag);
        check({tag, "_pass"}, pass, exp_pass);
        check({tag, "_fail"}, fail, !exp_pass);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_retry"}, retry_cnt, used);
        check({tag, "_id"}, id_value, att_id[used]);
        check({tag, "_ts"}, ts_value, att_ts[used]);
        check({tag, "_idreads"}, rd_id_cnt - id0, used + 1);
        check({tag, "_tsreads"}, rd_ts_cnt - ts0, used + 1);
        $display("txn %s: exp_pass=%0d retries=%0d id=%08h ts=%08h",
                 tag, exp_pass, used, att_id[used], att_ts[used]);
        last_id = att_id[used];
        last_ts = att_ts[used];
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, id0, ts0, st0;
        reset_n = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < 512; i++) begin
            id_words[i] = EXP_ID;
            ts_words[i] = EXP_TS;
        end

        // Reset values and the automatic first check with a zero-wait slave.
        repeat (3) @(negedge clock);
        check("rst_read", avm_read, 0);
        check("rst_addr", avm_address, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_id", id_value, 0);
        check("rst_ts", ts_value, 0);
        check("rst_retry", retry_cnt, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("auto_launch_busy", busy, 1);
        check("auto_launch_read", avm_read, 1);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("auto_latency", n, 5);
        check("auto_pass", pass, 1);
        check("auto_retry", retry_cnt, 0);
        check("auto_id", id_value, EXP_ID);
        check("auto_ts", ts_value, EXP_TS);
        check("auto_idreads", rd_id_cnt, 1);
        $display("txn auto: latency=%0d pass=%0d", n, pass);
        last_id = EXP_ID;
        last_ts = EXP_TS;

        stall_id_cfg = -1; stall_ts_cfg = -1; dly_id_cfg = -1; dly_ts_cfg = -1;

        // Two bad ID reads, then good.
        att_id[0] = EXP_ID ^ 32'h1; att_id[1] = EXP_ID ^ 32'h8000_0000;
        att_id[2] = EXP_ID;         att_id[3] = EXP_ID;
        for (int a = 0; a <= MAXR; a++) att_ts[a] = EXP_TS;
        run_check("retry2");

        // Persistent ID mismatch.
        for (int a = 0; a <= MAXR; a++) att_id[a] = 32'hBAD0_0000 + 32'(a);
        run_check("persist_bad");

        // Long stall on the timestamp read with start pulses that must be ignored.
        for (int a = 0; a <= MAXR; a++) begin att_id[a] = EXP_ID; att_ts[a] = EXP_TS; end
        stall_id_cfg = 0; stall_ts_cfg = 10; dly_id_cfg = 0; dly_ts_cfg = 0;
        id0 = rd_id_cnt; ts0 = rd_ts_cnt; st0 = stab_err;
        load_words(id0, ts0);
        pulse_start();
        n = 0;
        while (!(avm_read && avm_address) && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("stall_reach_rdts", avm_read && avm_address, 1);
        for (int k = 0; k < 3; k++) begin
            pulse_start();
            check("stall_busy", busy, 1);
            check("stall_read", avm_read, 1);
            check("stall_addr", avm_address, 1);
        end
        wait_done("stall");
        check("stall_pass", pass, 1);
        check("stall_idreads", rd_id_cnt - id0, 1);
        check("stall_tsreads", rd_ts_cnt - ts0, 1);
        check("stall_stability", stab_err - st0, 0);
        repeat (3) @(negedge clock);
        check("stall_no_relaunch", busy, 0);
        check("stall_still_done", done, 1);
        $display("txn stall: pass=%0d idreads=%0d", pass, rd_id_cnt - id0);

        // Reset during WT_ID with readdatavalid arriving after release.
        dly_id_cfg = 4;
        id0 = rd_id_cnt; ts0 = rd_ts_cnt;
        id_words[id0 % 512]       = 32'hDEAD_BEEF;
        id_words[(id0 + 1) % 512] = EXP_ID;
        ts_words[ts0 % 512]       = EXP_TS;
        pulse_start();
        n = 0;
        while (!(busy && !avm_read) && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("rstmid_in_wtid", busy && !avm_read, 1);
        reset_n = 1'b0;
        #1;
        check("rstmid_read", avm_read, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        check("rstmid_pass", pass, 0);
        check("rstmid_id", id_value, 0);
        check("rstmid_ts", ts_value, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        dly_id_cfg = 0;
        @(negedge clock);
        check("rstmid_relaunch", busy, 1);
        wait_done("rstmid");
        check("rstmid_pass2", pass, 1);
        check("rstmid_nostale", id_value, EXP_ID);
        check("rstmid_idreads", rd_id_cnt - id0, 2);
        check("rstmid_tsreads", rd_ts_cnt - ts0, 1);
        check("rstmid_retry", retry_cnt, 0);
        $display("txn reset_mid: id=%08h pass=%0d", id_value, pass);
        last_id = EXP_ID;
        last_ts = EXP_TS;

        // Randomized checks.
        stall_id_cfg = -1; stall_ts_cfg = -1; dly_id_cfg = -1; dly_ts_cfg = -1;
        for (int t = 0; t < 30; t++) begin
            for (int a = 0; a <= MAXR; a++) begin
                att_id[a] = ($urandom_range(2, 0) == 0) ? (EXP_ID ^ ($urandom | 32'h1)) : EXP_ID;
                att_ts[a] = ($urandom_range(3, 0) == 0) ? (EXP_TS ^ ($urandom | 32'h100)) : EXP_TS;
            end
            run_check($sformatf("rand%0d", t));
        end

`ifdef SYSID_CHECK_TIMEOUT_EN
        // readdatavalid never arrives: timeout after 16 cycles of WT_ID.
        stall_id_cfg = 0; dly_id_cfg = 100000;
        for (int a = 0; a <= MAXR; a++) begin att_id[a] = EXP_ID; att_ts[a] = EXP_TS; end
        load_words(rd_id_cnt, rd_ts_cnt);
        pulse_start();
        n = 0;
        while (!(busy && !avm_read) && n < 50) begin
            @(negedge clock);
            n++;
        end
        n = 0;
        while (!fail && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("tmo_cycles", n, 16);
        check("tmo_done", done, 1);
        check("tmo_busy", busy, 0);
        check("tmo_read", avm_read, 0);
        flush_req++;
        dly_id_cfg = 0;
        @(negedge clock);
        load_words(rd_id_cnt, rd_ts_cnt);
        pulse_start();
        wait_done("tmo_rerun");
        check("tmo_rerun_pass", pass, 1);
        $display("txn timeout: cycles=%0d rerun_pass=%0d", n, pass);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
